fp_div_sqrt_scheduler: RTL and testbench

FP_DIV_SQRT_SCHEDULER -- requirements
Module: fp_div_sqrt_scheduler

---
 rtl/fp_div_sqrt_scheduler_pkg.sv | 25 ++
 rtl/fp_rr_arbiter.sv | 51 +++++
 rtl/fp_div_sqrt_scheduler.sv | 126 ++++++++++++
 tb/tb_fp_div_sqrt_scheduler.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_sqrt_scheduler_pkg.sv
// Shared FPU div/sqrt types: scheduler FSM state, default iteration count and
// the iterative datapath stage register layout.
package fp_div_sqrt_scheduler_pkg;

   localparam int DIVSQRT_ITER_CYCLES = 26;
   localparam int DIVSQRT_QUO_W       = DIVSQRT_ITER_CYCLES;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_RUN  = 2'd1,
      DS_DONE = 2'd2
   } ds_state_e;

   typedef struct packed {
      logic                     is_sqrt;
      logic [DIVSQRT_QUO_W-1:0] quo;
      logic [DIVSQRT_QUO_W+1:0] rem;
   } divsqrt_stage_t;

   // Index/counter width that stays at least one bit for degenerate sizes.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting from the index after the last
// accepted grant; the pointer only moves when en_i confirms the grant.
module fp_rr_arbiter
   import fp_div_sqrt_scheduler_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = cnt_width(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_i,
   input  logic             en_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic             found;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      for (int off = 0; off < N; off++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i == (int'(ptr_q) + off) % N)) begin
               found     = 1'b1;
               gnt_o[i]  = 1'b1;
               gnt_idx_o = IDX_W'(i);
            end
         end
      end
   end

   always_comb begin
      ptr_d = '0;
      if (int'(gnt_idx_o) != N - 1) begin
         ptr_d = gnt_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (en_i && found) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/fp_div_sqrt_scheduler.sv
// Shares one iterative div/sqrt datapath among NUM_REQ requesters.
// Optional RSD_FPU_DIVSQRT_EARLY_OUT_EN: special-operand ops skip the iterations.
module fp_div_sqrt_scheduler
   import fp_div_sqrt_scheduler_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int ITER_CYCLES = DIVSQRT_ITER_CYCLES,
   parameter int TAG_W       = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_is_sqrt,
   input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
   input  logic [NUM_REQ-1:0]            req_special,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          dp_start,
   output logic                          dp_is_sqrt,
   output logic                          dp_step,
   input  logic                          flush,
   output logic                          res_valid,
   output logic [cnt_width(NUM_REQ)-1:0] res_owner,
   output logic [TAG_W-1:0]              res_tag,
   input  logic                          res_ready
);

   localparam int OWN_W = cnt_width(NUM_REQ);
   localparam int CNT_W = cnt_width(ITER_CYCLES);

   ds_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [OWN_W-1:0] owner_q;
   logic [TAG_W-1:0] tag_q;
   logic             sqrt_q;

   logic [NUM_REQ-1:0] gnt;
   logic [OWN_W-1:0]   gnt_idx;
   logic               grant_en;
   logic [TAG_W-1:0]   sel_tag;
   logic               sel_sqrt;
   logic               sel_special;
   logic               early_out;

   // Grants happen only from IDLE; flush and reset both veto a grant.
   assign grant_en = (state_q == DS_IDLE) && (|req_valid) && !flush && !rst;

   fp_rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (OWN_W)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_valid),
      .en_i      (grant_en),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   always_comb begin
      sel_tag     = '0;
      sel_sqrt    = 1'b0;
      sel_special = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_tag     = req_tag[i*TAG_W +: TAG_W];
            sel_sqrt    = req_is_sqrt[i];
            sel_special = req_special[i];
         end
      end
   end

`ifdef RSD_FPU_DIVSQRT_EARLY_OUT_EN
   assign early_out = sel_special;
`else
   logic unused_special;
   assign early_out      = 1'b0;
   assign unused_special = ^{req_special, sel_special};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DS_IDLE;
         cnt_q   <= '0;
         owner_q <= '0;
         tag_q   <= '0;
         sqrt_q  <= 1'b0;
      end else begin
         case (state_q)
            DS_IDLE: begin
               if (grant_en) begin
                  owner_q <= gnt_idx;
                  tag_q   <= sel_tag;
                  sqrt_q  <= sel_sqrt;
                  cnt_q   <= CNT_W'(ITER_CYCLES - 1);
                  state_q <= early_out ? DS_DONE : DS_RUN;
               end
            end
            DS_RUN: begin
               // Flush wins over expiry; the counter saturates at zero.
               if (flush) begin
                  state_q <= DS_IDLE;
               end else if (cnt_q == '0) begin
                  state_q <= DS_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DS_DONE: begin
               if (flush || res_ready) begin
                  state_q <= DS_IDLE;
               end
            end
            default: state_q <= DS_IDLE;
         endcase
      end
   end

   assign req_ready  = grant_en ? gnt : '0;
   assign dp_start   = grant_en;
   assign dp_is_sqrt = rst ? 1'b0 : (grant_en ? sel_sqrt : sqrt_q);
   assign dp_step    = (state_q == DS_RUN) && !flush && !rst;
   assign res_valid  = (state_q == DS_DONE) && !flush && !rst;
   assign res_owner  = rst ? '0 : owner_q;
   assign res_tag    = rst ? '0 : tag_q;

endmodule

// File: tb/tb_fp_div_sqrt_scheduler.sv
// Randomized self-checking bench for fp_div_sqrt_scheduler against a
// transaction-level round-robin / latency model.
module tb_fp_div_sqrt_scheduler;

   localparam int NR = 2;
   localparam int IT = 26;
   localparam int TW = 6;
`ifdef RSD_FPU_DIVSQRT_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NR-1:0] req_valid = '0;
   logic [NR-1:0] req_is_sqrt = '0;
   logic [NR*TW-1:0] req_tag = '0;
   logic [NR-1:0] req_special = '0;
   logic [NR-1:0] req_ready;
   logic          dp_start, dp_is_sqrt, dp_step;
   logic          flush = 1'b0;
   logic          res_valid;
   logic [0:0]    res_owner;
   logic [TW-1:0] res_tag;
   logic          res_ready = 1'b1;

   int total = 0;
   int bad   = 0;
   int mptr  = 0;

   always #5 clk = ~clk;

   fp_div_sqrt_scheduler #(.NUM_REQ(NR), .ITER_CYCLES(IT), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_is_sqrt(req_is_sqrt),
      .req_tag(req_tag), .req_special(req_special), .req_ready(req_ready),
      .dp_start(dp_start), .dp_is_sqrt(dp_is_sqrt), .dp_step(dp_step),
      .flush(flush), .res_valid(res_valid), .res_owner(res_owner),
      .res_tag(res_tag), .res_ready(res_ready)
   );

   function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
      for (int k = 0; k < NR; k++) if (v[(ptr + k) % NR]) return (ptr + k) % NR;
      return -1;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bit seen = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         next_cycle();
         if (c == 1) req_valid = '0;
         @(negedge clk);
         if (res_valid) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL drain_timeout: res_valid=0 after 40 cycles, required 1");
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 2'b11; res_ready = 1'b1;
      next_cycle(); next_cycle();
      @(negedge clk);
      total++;
      if ({req_ready, dp_start, dp_step, res_valid, dp_is_sqrt, res_owner} !== '0 || res_tag !== '0) begin
         bad++;
         $display("FAIL reset_during: rdy=%b st=%b step=%b rv=%b own=%b tag=%0d, required all 0",
                  req_ready, dp_start, dp_step, res_valid, res_owner, res_tag);
      end
      next_cycle();
      rst = 1'b0; req_valid = '0;
      @(negedge clk);
      total++;
      if ({req_ready, dp_start, dp_step, res_valid, dp_is_sqrt, res_owner} !== '0 || res_tag !== '0) begin
         bad++;
         $display("FAIL reset_after: rdy=%b st=%b step=%b rv=%b, required all 0",
                  req_ready, dp_start, dp_step, res_valid);
      end
      mptr = 0;
   endtask

   task automatic test_single();
      int bad_steps = 0;
      next_cycle();
      req_valid = 2'b01; req_tag = {6'd0, 6'd5}; req_is_sqrt = '0; req_special = '0;
      @(negedge clk);
      total++;
      if (req_ready !== 2'b01 || dp_start !== 1'b1 || dp_is_sqrt !== 1'b0) begin
         bad++;
         $display("FAIL single_grant: rdy=%b start=%b sqrt=%b, required 01/1/0", req_ready, dp_start, dp_is_sqrt);
      end
      mptr = 1;
      for (int c = 1; c <= IT; c++) begin
         next_cycle();
         if (c == 1) req_valid = '0;
         @(negedge clk);
         if (dp_step !== 1'b1 || res_valid !== 1'b0 || req_ready !== '0) bad_steps++;
      end
      total++;
      if (bad_steps != 0) begin
         bad++;
         $display("FAIL single_steps: %0d wrong cycles in 1..%0d, required 0", bad_steps, IT);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (res_valid !== 1'b1 || res_owner !== 1'b0 || res_tag !== 6'd5 || dp_step !== 1'b0) begin
         bad++;
         $display("FAIL single_result: rv=%b own=%0d tag=%0d step=%b, required 1/0/5/0",
                  res_valid, res_owner, res_tag, dp_step);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (res_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_accept: rv=%b, required 0", res_valid);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         logic [NR-1:0] v, sq, sp, eg;
         logic [TW-1:0] tg [NR];
         int e, lat, steps, exp_lat, exp_steps;
         logic [0:0] got_own;
         logic [TW-1:0] got_tag;
         v = NR'($urandom_range(1, 3));
         sq = NR'($urandom_range(0, 3));
         sp = NR'($urandom_range(0, 3));
         for (int i = 0; i < NR; i++) tg[i] = TW'($urandom);
         next_cycle();
         req_valid = v; req_is_sqrt = sq; req_special = sp; req_tag = {tg[1], tg[0]};
         @(negedge clk);
         e = rr_pick(v, mptr);
         eg = NR'(1 << e);
         total++;
         if (req_ready !== eg || dp_start !== 1'b1 || dp_is_sqrt !== sq[e]) begin
            bad++;
            $display("FAIL rand_grant: rdy=%b start=%b sqrt=%b, required %b/1/%b", req_ready, dp_start, dp_is_sqrt, eg, sq[e]);
         end
         mptr = (e + 1) % NR;
         exp_lat   = (EARLY && sp[e]) ? 1 : IT + 1;
         exp_steps = (EARLY && sp[e]) ? 0 : IT;
         lat = -1; steps = 0; got_own = '0; got_tag = '0;
         for (int c = 1; c <= 40; c++) begin
            next_cycle();
            if (c == 1) req_valid = '0;
            @(negedge clk);
            if (dp_step === 1'b1) steps++;
            if (res_valid === 1'b1) begin
               lat = c; got_own = res_owner; got_tag = res_tag;
               break;
            end
         end
         total++;
         if (lat != exp_lat) begin
            bad++;
            $display("FAIL rand_latency: got %0d, required %0d", lat, exp_lat);
         end
         total++;
         if (got_own !== 1'(e) || got_tag !== tg[e]) begin
            bad++;
            $display("FAIL rand_result: own=%0d tag=%0d, required %0d/%0d", got_own, got_tag, e, tg[e]);
         end
         total++;
         if (steps != exp_steps) begin
            bad++;
            $display("FAIL rand_steps: got %0d, required %0d", steps, exp_steps);
         end
      end
      req_special = '0;
   endtask

   task automatic test_contention();
      logic [NR-1:0] seen [$];
      logic [NR-1:0] eg;
      int e;
      next_cycle();
      req_valid = 2'b11; req_is_sqrt = '0; req_special = '0; res_ready = 1'b1;
      req_tag = {TW'($urandom), TW'($urandom)};
      for (int c = 0; c < 4 * (IT + 2); c++) begin
         if (c > 0) next_cycle();
         @(negedge clk);
         if (req_ready !== '0) seen.push_back(req_ready);
      end
      for (int k = 0; k < 4; k++) begin
         e = rr_pick(2'b11, mptr);
         mptr = (e + 1) % NR;
         eg = NR'(1 << e);
         total++;
         if (seen.size() <= k || seen[k] !== eg) begin
            bad++;
            $display("FAIL contention_grant%0d: got %b, required %b", k, (seen.size() > k) ? seen[k] : 2'b00, eg);
         end
      end
      total++;
      if (seen.size() != 4) begin
         bad++;
         $display("FAIL contention_count: %0d grants, required 4", seen.size());
      end
      next_cycle();
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      logic [TW-1:0] tg [NR];
      int e, lat, hold_bad, nogr;
      logic [NR-1:0] eg;
      for (int i = 0; i < NR; i++) tg[i] = TW'($urandom);
      next_cycle();
      req_valid = 2'b11; req_tag = {tg[1], tg[0]}; res_ready = 1'b0;
      @(negedge clk);
      e = rr_pick(2'b11, mptr);
      mptr = (e + 1) % NR;
      eg = NR'(1 << e);
      total++;
      if (req_ready !== eg) begin
         bad++;
         $display("FAIL bp_grant: got %b, required %b", req_ready, eg);
      end
      lat = -1; nogr = 0;
      for (int c = 1; c <= 40; c++) begin
         next_cycle();
         @(negedge clk);
         if (req_ready !== '0) nogr++;
         if (res_valid === 1'b1) begin lat = c; break; end
      end
      total++;
      if (lat != IT + 1) begin
         bad++;
         $display("FAIL bp_latency: got %0d, required %0d", lat, IT + 1);
      end
      hold_bad = 0;
      for (int k = 0; k < 10; k++) begin
         next_cycle();
         @(negedge clk);
         if (res_valid !== 1'b1 || res_tag !== tg[e] || res_owner !== 1'(e)) hold_bad++;
         if (req_ready !== '0) nogr++;
      end
      total++;
      if (hold_bad != 0 || nogr != 0) begin
         bad++;
         $display("FAIL bp_hold: %0d unstable cycles, %0d stray grants, required 0/0", hold_bad, nogr);
      end
      next_cycle();
      res_ready = 1'b1;
      @(negedge clk);
      total++;
      if (res_valid !== 1'b1 || req_ready !== '0) begin
         bad++;
         $display("FAIL bp_accept: rv=%b rdy=%b, required 1/00", res_valid, req_ready);
      end
      next_cycle();
      @(negedge clk);
      e = rr_pick(2'b11, mptr);
      mptr = (e + 1) % NR;
      eg = NR'(1 << e);
      total++;
      if (res_valid !== 1'b0 || req_ready !== eg) begin
         bad++;
         $display("FAIL bp_idle_next: rv=%b rdy=%b, required 0/%b", res_valid, req_ready, eg);
      end
      drain();
   endtask

   task automatic test_flush();
      int e, quiet_bad;
      logic [NR-1:0] eg;
      next_cycle();
      req_valid = 2'b11; res_ready = 1'b1; req_tag = {TW'($urandom), TW'($urandom)};
      @(negedge clk);
      e = rr_pick(2'b11, mptr);
      mptr = (e + 1) % NR;
      total++;
      if (req_ready !== NR'(1 << e)) begin
         bad++;
         $display("FAIL flush_grant: got %b, required %b", req_ready, NR'(1 << e));
      end
      for (int c = 1; c <= 10; c++) begin
         next_cycle();
         if (c == 1) req_valid = '0;
         if (c == 10) flush = 1'b1;
         @(negedge clk);
      end
      next_cycle();
      flush = 1'b0;
      @(negedge clk);
      total++;
      if (dp_step !== 1'b0 || res_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_idle: step=%b rv=%b, required 0/0", dp_step, res_valid);
      end
      quiet_bad = 0;
      for (int c = 0; c < 30; c++) begin
         next_cycle();
         @(negedge clk);
         if (res_valid !== 1'b0 || dp_step !== 1'b0) quiet_bad++;
      end
      total++;
      if (quiet_bad != 0) begin
         bad++;
         $display("FAIL flush_quiet: %0d active cycles, required 0", quiet_bad);
      end
      next_cycle();
      req_valid = 2'b11; flush = 1'b1;
      @(negedge clk);
      total++;
      if (req_ready !== '0 || dp_start !== 1'b0) begin
         bad++;
         $display("FAIL flush_blocks_grant: rdy=%b start=%b, required 00/0", req_ready, dp_start);
      end
      next_cycle();
      flush = 1'b0;
      @(negedge clk);
      eg = NR'(1 << ((e + 1) % NR));
      mptr = (e + 2) % NR;
      total++;
      if (req_ready !== eg) begin
         bad++;
         $display("FAIL flush_next_owner: got %b, required %b", req_ready, eg);
      end
      drain();
   endtask

   task automatic test_special();
      int r, lat, steps, exp_lat, exp_steps;
      logic [TW-1:0] tg;
      r = $urandom_range(0, 1);
      tg = TW'($urandom);
      next_cycle();
      req_valid = NR'(1 << r); req_is_sqrt = 2'b11; req_special = 2'b11; req_tag = {tg, tg};
      @(negedge clk);
      mptr = (r + 1) % NR;
      total++;
      if (req_ready !== NR'(1 << r) || dp_start !== 1'b1 || dp_is_sqrt !== 1'b1) begin
         bad++;
         $display("FAIL special_grant: rdy=%b start=%b sqrt=%b, required %b/1/1", req_ready, dp_start, dp_is_sqrt, NR'(1 << r));
      end
      exp_lat = EARLY ? 1 : IT + 1;
      exp_steps = EARLY ? 0 : IT;
      lat = -1; steps = 0;
      for (int c = 1; c <= 40; c++) begin
         next_cycle();
         if (c == 1) req_valid = '0;
         @(negedge clk);
         if (dp_step === 1'b1) steps++;
         if (res_valid === 1'b1) begin lat = c; break; end
      end
      total++;
      if (lat != exp_lat || steps != exp_steps) begin
         bad++;
         $display("FAIL special_timing: lat=%0d steps=%0d, required %0d/%0d", lat, steps, exp_lat, exp_steps);
      end
      req_special = '0; req_is_sqrt = '0;
   endtask

   task automatic test_rst_mid_run();
      int quiet_bad;
      next_cycle();
      req_valid = 2'b01; req_tag = {TW'(0), TW'($urandom)};
      @(negedge clk);
      total++;
      if (req_ready !== 2'b01) begin
         bad++;
         $display("FAIL rstrun_grant: got %b, required 01", req_ready);
      end
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         if (c == 1) req_valid = '0;
         @(negedge clk);
      end
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({req_ready, dp_start, dp_step, res_valid, dp_is_sqrt, res_owner} !== '0 || res_tag !== '0) begin
         bad++;
         $display("FAIL rstrun_during: step=%b rv=%b tag=%0d, required all 0", dp_step, res_valid, res_tag);
      end
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({req_ready, dp_start, dp_step, res_valid, dp_is_sqrt, res_owner} !== '0 || res_tag !== '0) begin
         bad++;
         $display("FAIL rstrun_after: step=%b rv=%b tag=%0d, required all 0", dp_step, res_valid, res_tag);
      end
      mptr = 0;
      quiet_bad = 0;
      for (int c = 0; c < 30; c++) begin
         next_cycle();
         @(negedge clk);
         if (res_valid !== 1'b0 || dp_step !== 1'b0) quiet_bad++;
      end
      total++;
      if (quiet_bad != 0) begin
         bad++;
         $display("FAIL rstrun_quiet: %0d active cycles, required 0", quiet_bad);
      end
      next_cycle();
      req_valid = 2'b11;
      @(negedge clk);
      total++;
      if (req_ready !== NR'(1 << rr_pick(2'b11, mptr))) begin
         bad++;
         $display("FAIL rstrun_ptr: got %b, required %b", req_ready, NR'(1 << rr_pick(2'b11, mptr)));
      end
      mptr = 1;
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_random();
      test_contention();
      test_backpressure();
      test_flush();
      test_special();
      test_rst_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
